// File: rtl/instruction_queue_pkg.sv
// Shared constants for the fetch-to-decode instruction queue.
package instruction_queue_pkg;

    localparam int unsigned IqWordWidth    = 32;
    localparam int unsigned IqDefaultDepth = 4;
    localparam logic [31:0] IqEmptyWord    = 32'h0;

endpackage

// File: rtl/instruction_queue.sv
// Show-ahead FIFO of {PC, instruction} pairs between fetch and decode.
// full backpressures fetch; flush (branch taken) empties the queue.
module instruction_queue
    import instruction_queue_pkg::*;
#(
    parameter int unsigned DEPTH = IqDefaultDepth,
    parameter int unsigned WIDTH = IqWordWidth
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_pc,
    input  logic [WIDTH-1:0]         in_instruction,
    output logic                     full,
    input  logic                     flush,
    input  logic                     freeze,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_pc,
    output logic [WIDTH-1:0]         out_instruction,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] pc_mem_q    [DEPTH];
    logic [WIDTH-1:0] instr_mem_q [DEPTH];

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    logic push;
    logic pop;

    assign full      = (count_q == CntW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign count     = count_q;

    // full is evaluated before any same-cycle pop, so a full queue rejects pushes.
    assign push = in_valid & ~full & ~flush;
    assign pop  = out_valid & ~freeze & ~flush;

    always_comb begin
        out_pc          = WIDTH'(IqEmptyWord);
        out_instruction = WIDTH'(IqEmptyWord);
        if (out_valid) begin
            out_pc          = pc_mem_q[rd_ptr_q];
            out_instruction = instr_mem_q[rd_ptr_q];
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never reset; stale words are masked by out_valid.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            pc_mem_q[wr_ptr_q]    <= in_pc;
            instr_mem_q[wr_ptr_q] <= in_instruction;
        end
    end

endmodule

// File: tb/tb_instruction_queue.sv
// Directed and randomized checks of instruction_queue against a queue-based model.
module tb_instruction_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned WIDTH = 32;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_pc = '0;
    logic [31:0] in_instruction = '0;
    logic        full;
    logic        flush = 1'b0;
    logic        freeze = 1'b0;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instruction;
    logic [2:0]  count;

    int vectors = 0;
    int miscompares = 0;
    entry_t model_q[$];

    always #5 clk = ~clk;

    instruction_queue #(
        .DEPTH(DEPTH),
        .WIDTH(WIDTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_pc          (in_pc),
        .in_instruction (in_instruction),
        .full           (full),
        .flush          (flush),
        .freeze         (freeze),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_instruction(out_instruction),
        .count          (count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        int n;
        n = model_q.size();
        chk({tag, ".count"}, 32'(count), 32'(n));
        chk({tag, ".full"}, 32'(full), 32'(n == DEPTH));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(n != 0));
        chk({tag, ".out_pc"}, out_pc, (n != 0) ? model_q[0].pc : 32'h0);
        chk({tag, ".out_instr"}, out_instruction, (n != 0) ? model_q[0].ins : 32'h0);
    endtask

    // Apply one clock of inputs, advance the model, then compare after the edge.
    task automatic step(input string tag, input bit v, input logic [31:0] pc,
                        input logic [31:0] ins, input bit fl, input bit fr, input bit r);
        bit do_push;
        bit do_pop;
        entry_t e;
        rst            = r;
        in_valid       = v;
        in_pc          = pc;
        in_instruction = ins;
        flush          = fl;
        freeze         = fr;
        do_push = v && (model_q.size() < DEPTH) && !fl;
        do_pop  = (model_q.size() != 0) && !fr && !fl;
        @(posedge clk);
        #1;
        if (r || fl) begin
            model_q.delete();
        end else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) begin
                e.pc  = pc;
                e.ins = ins;
                model_q.push_back(e);
            end
        end
        check_model(tag);
    endtask

    initial begin
        logic [31:0] prev_pc;

        // Reset, then a single push into an empty queue.
        step("rst0", 0, 0, 0, 0, 0, 1);
        chk("rst0.count0", 32'(count), 32'd0);
        step("s1_push", 1, 32'd4, 32'hE3A00001, 0, 1, 0);
        chk("s1.out_valid", 32'(out_valid), 32'd1);
        chk("s1.out_pc", out_pc, 32'd4);
        chk("s1.count", 32'(count), 32'd1);

        // Fill with freeze held, reject fifth push, then drain in order.
        step("s2_rst", 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            step("s2_fill", 1, 32'(4 + 4 * i), 32'hA000_0000 + 32'(i), 0, 1, 0);
        end
        chk("s2.full", 32'(full), 32'd1);
        chk("s2.count4", 32'(count), 32'd4);
        step("s2_push5", 1, 32'd20, 32'hA000_0004, 0, 1, 0);
        chk("s2.count_after5", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("s2.drain_pc", out_pc, 32'(4 + 4 * i));
            step("s2_drain", 0, 0, 0, 0, 0, 0);
        end
        chk("s2.empty", 32'(out_valid), 32'd0);

        // Full queue: pop with push rejected, then push accepted.
        for (int i = 0; i < 4; i++) begin
            step("s3_fill", 1, 32'(100 + 4 * i), 32'hB000_0000 + 32'(i), 0, 1, 0);
        end
        step("s3_popush", 1, 32'd200, 32'hB000_00FF, 0, 0, 0);
        chk("s3.count3", 32'(count), 32'd3);
        chk("s3.full0", 32'(full), 32'd0);
        step("s3_push", 1, 32'd204, 32'hB000_0100, 0, 1, 0);
        chk("s3.count4", 32'(count), 32'd4);

        // Steady push/pop across the pointer wrap.
        step("s4_rst", 0, 0, 0, 0, 0, 1);
        step("s4_seed", 1, 32'd0, 32'hC000_0000, 0, 1, 0);
        prev_pc = out_pc;
        for (int i = 1; i <= 10; i++) begin
            step("s4_stream", 1, 32'(4 * i), 32'hC000_0000 + 32'(i), 0, 0, 0);
            chk("s4.count1", 32'(count), 32'd1);
            chk("s4.pc_inc", out_pc, prev_pc + 32'd4);
            prev_pc = out_pc;
        end

        // Flush with a simultaneous push.
        step("s5_rst", 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step("s5_fill", 1, 32'(28 + 4 * i), 32'hD000_0000 + 32'(i), 0, 1, 0);
        end
        step("s5_flush", 1, 32'd40, 32'hD000_0040, 1, 1, 0);
        chk("s5.count0", 32'(count), 32'd0);
        chk("s5.out_valid0", 32'(out_valid), 32'd0);
        chk("s5.out_pc0", out_pc, 32'd0);
        step("s5_after", 0, 0, 0, 0, 1, 0);
        chk("s5.pc40_absent", 32'(out_valid), 32'd0);

        // Reset mid-operation with two entries queued.
        step("s6_fill", 1, 32'd60, 32'hE000_0000, 0, 1, 0);
        step("s6_fill", 1, 32'd64, 32'hE000_0001, 0, 1, 0);
        chk("s6.count2", 32'(count), 32'd2);
        step("s6_rst", 1, 32'd68, 32'hE000_0002, 0, 0, 1);
        chk("s6.count0", 32'(count), 32'd0);
        chk("s6.full0", 32'(full), 32'd0);
        chk("s6.instr0", out_instruction, 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 $urandom_range(0, 99) < 65,
                 $urandom(),
                 $urandom(),
                 $urandom_range(0, 99) < 5,
                 $urandom_range(0, 99) < 45,
                 $urandom_range(0, 99) < 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instruction_queue.md
INSTRUCTION_QUEUE -- requirements
Module: instruction_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of {PC, instruction} entries; it SHALL be a power of two, at least 2.
REQ-002 The block SHALL have parameter WIDTH, default 32, giving the width of the PC and instruction fields.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 The block SHALL have these ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  fetch stage presents a valid entry.
- in_pc  input  WIDTH  PC+4 value from fetch.
- in_instruction  input  WIDTH  fetched instruction word.
- full  output  1  queue full; drives the fetch-stage freeze input.
- flush  input  1  Branch_taken; discards all queued entries.
- freeze  input  1  decode side stalled; the head entry is not consumed.
- out_valid  output  1  head entry valid for decode.
- out_pc  output  WIDTH  head entry PC.
- out_instruction  output  WIDTH  head entry instruction.
- count  output  log2(DEPTH)+1  number of occupied entries.

Function
REQ-005 A push SHALL occur on a rising edge when in_valid=1, full=0 and flush=0; the entry is written at the write pointer, which then advances.
REQ-006 A pop SHALL occur on a rising edge when out_valid=1, freeze=0 and flush=0; the read pointer then advances.
REQ-007 Both pointers SHALL wrap modulo DEPTH, with no gap or duplicate across the wrap.
REQ-008 count SHALL rise by 1 on push only, fall by 1 on pop only, and hold on simultaneous push and pop.
REQ-009 full SHALL equal (count==DEPTH).
REQ-010 out_valid SHALL equal (count!=0).
REQ-011 The outputs SHALL be show-ahead:
- out_pc and out_instruction reflect the head entry combinationally from storage.
- They SHALL be 0 whenever out_valid=0.
REQ-012 Latency: an entry pushed into an empty queue SHALL appear at the outputs with out_valid=1 in the cycle after the push edge; there SHALL be no same-cycle bypass.
REQ-013 When full=1, in_valid SHALL be ignored even if a pop occurs in the same cycle. full deasserts the cycle after a pop.
REQ-014 When empty, freeze SHALL have no effect and no pop occurs.
REQ-015 Flush SHALL take priority over push and pop:
- On a flush edge, both pointers and count return to 0.
- Any simultaneous push is discarded.
- out_valid=0 and full=0 in the following cycle.
REQ-016 Storage contents SHALL NOT be observable except through a valid head entry.
REQ-017 Entries SHALL leave in strict FIFO order; the PC and instruction of an entry always stay paired.

Reset
REQ-018 On a rst edge, pointers and count SHALL become 0. The outputs then SHALL be out_valid=0, full=0, out_pc=0, out_instruction=0 and count=0.
REQ-019 rst SHALL override flush, push and pop in the same cycle, and reset mid-operation SHALL discard all entries.
REQ-020 Storage array entries SHALL NOT require reset.

Structure
REQ-021 Constants SHALL live in the shared defines include:
- word width 32.
- default queue depth 4.
- empty-output value 32'h0.
REQ-022 The block SHALL be a single module with inline storage array, pointers and counter; no sub-module is required.
REQ-023 The block SHALL sit between InstructionFetchStage and the instruction decode stage:
- full connects to the fetch freeze input.
- flush is the same net as Branch_taken.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Reset, then push PC=4/instr=32'hE3A00001 -> next cycle out_valid=1, out_pc=4, count=1.
- Push 4 entries with freeze=1 (PC 4, 8, 12, 16) -> full=1, count=4; 5th push (PC 20) is ignored; release freeze -> entries leave in order 4, 8, 12, 16, then out_valid=0.
- Full queue, then pop and push in the same cycle -> push rejected, count=3; next cycle push accepted, count=4.
- Steady simultaneous push/pop for 10 cycles across pointer wrap -> count constant at 1, PCs strictly increasing by 4.
- Queue holds 3 entries, then flush=1 with in_valid=1 (PC 40) -> next cycle count=0, out_valid=0, out_pc=0; PC 40 is absent.
- rst asserted with count=2 and flush=0 -> next cycle count=0, full=0, out_instruction=0.
